// File: rtl/seg7_digit_sequencer.sv
// Single-digit seven-segment sequencer: prescaled up/down modulo counter with load,
// wrap pulse, per-tick blinking decimal point and combinational hex decode.
module seg7_digit_sequencer #(
  parameter int PRESCALE     = 1,
  parameter int MODULUS      = 10,
  parameter int COMMON_ANODE = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       DIR,
  input  logic       LOAD,
  input  logic [3:0] LOAD_VAL,
  output logic [3:0] DIGIT,
  output logic       WRAP,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       DP
);

  localparam int         PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0] D_LAST  = 4'(MODULUS - 1);
  localparam logic [4:0] D_MOD   = 5'(MODULUS);
  localparam logic       POL     = (COMMON_ANODE != 0);

  if (MODULUS < 2 || MODULUS > 16 || PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_param
    $error("seg7_digit_sequencer: illegal PRESCALE or MODULUS");
  end

  logic [PW-1:0] pc;
  logic          dp_q;
  logic          tick;
  logic          at_top;
  logic          at_zero;
  logic [3:0]    load_digit;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign tick       = EN && (pc == PC_LAST);
  assign at_top     = (DIGIT == D_LAST);
  assign at_zero    = (DIGIT == 4'd0);
  // Out-of-range load values fall back to zero so DIGIT never leaves 0..MODULUS-1.
  assign load_digit = ({1'b0, LOAD_VAL} < D_MOD) ? LOAD_VAL : 4'd0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc    <= '0;
      DIGIT <= 4'd0;
      WRAP  <= 1'b0;
      dp_q  <= 1'b0;
    end else if (LOAD) begin
      pc    <= '0;
      DIGIT <= load_digit;
      WRAP  <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (tick) begin
        pc   <= '0;
        dp_q <= ~dp_q;
        if (!DIR) begin
          DIGIT <= at_top ? 4'd0 : DIGIT + 4'd1;
          WRAP  <= at_top;
        end else begin
          DIGIT <= at_zero ? D_LAST : DIGIT - 4'd1;
          WRAP  <= at_zero;
        end
      end else if (EN) begin
        pc <= pc + 1'b1;
      end
    end
  end

  // Decode straight off the DIGIT register; polarity folded in last.
  assign {A, B, C, D, E, F, G} = seg7_decode(DIGIT) ^ {7{POL}};
  assign DP = dp_q ^ POL;

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// Randomised scoreboard bench for seg7_digit_sequencer: two instances with different
// prescale/modulus/polarity share stimulus and are checked against a behavioural model.
module tb_seg7_digit_sequencer;

  localparam int PS[2] = '{3, 1};
  localparam int MD[2] = '{10, 16};
  localparam int CA[2] = '{0, 1};
  localparam bit [6:0] HEX[16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                   7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0, DIR = 1'b0, LOAD = 1'b0;
  logic [3:0] LOAD_VAL = 4'd0;

  logic [3:0] dig0, dig1;
  logic       wr0, wr1, dp0, dp1;
  logic       a0, b0, c0, d0, e0, f0, g0;
  logic       a1, b1, c1, d1, e1, f1, g1;

  seg7_digit_sequencer #(.PRESCALE(3), .MODULUS(10), .COMMON_ANODE(0)) dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .DIGIT(dig0), .WRAP(wr0), .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0), .G(g0),
    .DP(dp0));

  seg7_digit_sequencer #(.PRESCALE(1), .MODULUS(16), .COMMON_ANODE(1)) dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .DIGIT(dig1), .WRAP(wr1), .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1),
    .DP(dp1));

  always #5 CLK = ~CLK;

  typedef struct {
    int dig[2];
    int wr[2];
    int seg[2];
    int dp[2];
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pc[2], m_dig[2], m_dp[2], m_wr[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    for (int k = 0; k < 2; k++) begin
      x.dig[k] = m_dig[k];
      x.wr[k]  = m_wr[k];
      x.seg[k] = CA[k] ? (~HEX[m_dig[k]] & 7'h7f) : HEX[m_dig[k]];
      x.dp[k]  = m_dp[k] ^ CA[k];
    end
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_dig[k] = 0; m_dp[k] = 0; m_wr[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit en, input bit dir, input bit ld, input int lv);
    m_wr[k] = 0;
    if (ld) begin
      m_dig[k] = (lv < MD[k]) ? lv : 0;
      m_pc[k]  = 0;
    end else if (en) begin
      if (m_pc[k] == PS[k] - 1) begin
        m_pc[k] = 0;
        m_dp[k] = m_dp[k] ^ 1;
        if (!dir) begin
          m_dig[k] = (m_dig[k] + 1) % MD[k];
          m_wr[k]  = (m_dig[k] == 0);
        end else begin
          m_dig[k] = (m_dig[k] + MD[k] - 1) % MD[k];
          m_wr[k]  = (m_dig[k] == MD[k] - 1);
        end
      end else begin
        m_pc[k]++;
      end
    end
  endtask

  task automatic compare(input string tag, input exp_t x);
    chk({tag, "_digit0"}, 32'(dig0), 32'(x.dig[0]));
    chk({tag, "_wrap0"},  32'(wr0),  32'(x.wr[0]));
    chk({tag, "_seg0"},   32'({a0, b0, c0, d0, e0, f0, g0}), 32'(x.seg[0]));
    chk({tag, "_dp0"},    32'(dp0),  32'(x.dp[0]));
    chk({tag, "_digit1"}, 32'(dig1), 32'(x.dig[1]));
    chk({tag, "_wrap1"},  32'(wr1),  32'(x.wr[1]));
    chk({tag, "_seg1"},   32'({a1, b1, c1, d1, e1, f1, g1}), 32'(x.seg[1]));
    chk({tag, "_dp1"},    32'(dp1),  32'(x.dp[1]));
  endtask

  // Monitor: outputs are presented every cycle; compare whatever the driver queued.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) compare("cycle", q.pop_front());
    end
  end

  initial begin
    bit in_reset;
    bit en_r, dir_r, ld_r;
    int lv;
    model_reset();
    #13;
    compare("reset", model_out());
    @(negedge CLK);
    RST = 1'b1;
    in_reset = 0;
    dir_r = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (in_reset) begin
        RST = 1'b1;
        in_reset = 0;
      end else if (i > 30 && $urandom_range(0, 149) == 0) begin
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        compare("async_reset", model_out());
        in_reset = 1;
        continue;
      end
      if (i < 24) begin
        en_r = 1; dir_r = 0; ld_r = 0; lv = 0;
      end else begin
        en_r = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) dir_r = ~dir_r;
        ld_r = ($urandom_range(0, 24) == 0);
        lv   = $urandom_range(0, 15);
      end
      EN = en_r; DIR = dir_r; LOAD = ld_r; LOAD_VAL = 4'(lv);
      for (int k = 0; k < 2; k++) model_step(k, en_r, dir_r, ld_r, lv);
      q.push_back(model_out());
    end
    @(negedge CLK);
    EN = 1'b0; LOAD = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
